// File: rtl/btn_pkg.sv
// Shared types and defaults for the button gesture classifier.
// Timing constants are in 10 ns clock cycles.
package btn_pkg;

    typedef enum logic [2:0] {
        e_idle      = 3'd0,
        e_press1    = 3'd1,
        e_long_hold = 3'd2,
        e_gap       = 3'd3,
        e_press2    = 3'd4
    } t_press_state;

    localparam int LONG_PERIOD_DEFAULT = 100_000_000;
    localparam int DCLICK_GAP_DEFAULT  = 30_000_000;

    function automatic int timer_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/tick_timer.sv
// Loadable down-counter that saturates at zero; expire flags a zero count.
module tick_timer #(
    parameter int WIDTH = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic             i_dec,
    input  logic [WIDTH-1:0] i_value,
    output logic             o_expire
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            count <= '0;
        end else if (i_load) begin
            count <= i_value;
        end else if (i_dec && (count != '0)) begin
            count <= count - WIDTH'(1);
        end
    end

    assign o_expire = (count == '0);

endmodule

// File: rtl/btn_press_classifier.sv
// Classifies debounced button gestures into single, double and long presses,
// each reported as a registered one-cycle pulse.
module btn_press_classifier
    import btn_pkg::*;
#(
    parameter int LONG_PERIOD_10NS = LONG_PERIOD_DEFAULT,
    parameter int DCLICK_GAP_10NS  = DCLICK_GAP_DEFAULT
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_level,
    input  logic i_rising,
    output logic o_single,
    output logic o_double,
    output logic o_long,
    output logic o_busy
);

    localparam int TW = timer_width(LONG_PERIOD_10NS, DCLICK_GAP_10NS);
    localparam logic [TW-1:0] LONG_LOAD = TW'(LONG_PERIOD_10NS - 1);
    localparam logic [TW-1:0] GAP_LOAD  = TW'(DCLICK_GAP_10NS - 1);

    t_press_state    state, state_nxt;
    logic            rising_p1;
    logic            edge_armed;
    logic            press_ev, release_ev;
    logic            tmr_load, tmr_expire;
    logic [TW-1:0]   tmr_value;
    logic            single_nxt, double_nxt, long_nxt;
    logic            single_p1, double_p1, long_p1;

    // A rising line still high when reset lifts must drop once before it can count.
    assign press_ev   = i_rising && !rising_p1 && edge_armed;
    assign release_ev = !i_level;

    tick_timer #(.WIDTH(TW)) u_timer (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_load   (tmr_load),
        .i_dec    (!tmr_load),
        .i_value  (tmr_value),
        .o_expire (tmr_expire)
    );

    always_comb begin
        state_nxt  = state;
        tmr_load   = 1'b0;
        tmr_value  = '0;
        single_nxt = 1'b0;
        double_nxt = 1'b0;
        long_nxt   = 1'b0;
        case (state)
            e_idle: begin
                if (press_ev) begin
                    state_nxt = e_press1;
                    tmr_load  = 1'b1;
                    tmr_value = LONG_LOAD;
                end
            end
            e_press1: begin
                if (release_ev) begin
                    state_nxt = e_gap;
                    tmr_load  = 1'b1;
                    tmr_value = GAP_LOAD;
                end else if (tmr_expire) begin
                    state_nxt = e_long_hold;
                    long_nxt  = 1'b1;
                end
            end
            e_long_hold: begin
                if (release_ev) state_nxt = e_idle;
            end
            e_gap: begin
                if (press_ev) begin
                    state_nxt = e_press2;
                end else if (tmr_expire) begin
                    state_nxt  = e_idle;
                    single_nxt = 1'b1;
                end
            end
            e_press2: begin
                if (release_ev) begin
                    state_nxt  = e_idle;
                    double_nxt = 1'b1;
                end
            end
            default: state_nxt = e_idle;
        endcase
    end

    // Stage boundary: state, edge detector and event pulses registered together.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state      <= e_idle;
            rising_p1  <= 1'b0;
            edge_armed <= 1'b0;
            single_p1  <= 1'b0;
            double_p1  <= 1'b0;
            long_p1    <= 1'b0;
        end else begin
            state      <= state_nxt;
            rising_p1  <= i_rising;
            edge_armed <= edge_armed || !i_rising;
            single_p1  <= single_nxt;
            double_p1  <= double_nxt;
            long_p1    <= long_nxt;
        end
    end

    assign o_single = single_p1;
    assign o_double = double_p1;
    assign o_long   = long_p1;
    assign o_busy   = (state != e_idle);

endmodule

// File: tb/tb_btn_press_classifier.sv
// Bench for btn_press_classifier: directed gesture scenarios plus randomized
// gestures checked cycle by cycle against a step-count reference model.
module tb_btn_press_classifier;

    localparam int L = 20;
    localparam int D = 10;

    localparam int M_IDLE = 0;
    localparam int M_P1   = 1;
    localparam int M_LONG = 2;
    localparam int M_GAP  = 3;
    localparam int M_P2   = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic level;
    logic rising;
    logic o_single, o_double, o_long, o_busy;

    int checks = 0;
    int failures = 0;

    // reference model state (step numbers, not counters)
    int m_mode, m_ent;
    bit m_rq, m_armed;
    bit m_single, m_double, m_long;

    int n = 0;
    int sgl_cnt, dbl_cnt, lng_cnt;
    int sgl_step, dbl_step, lng_step;
    logic sgl_busy;

    btn_press_classifier #(
        .LONG_PERIOD_10NS (L),
        .DCLICK_GAP_10NS  (D)
    ) dut (
        .i_clk    (clk),
        .i_rst_n  (rst_n),
        .i_level  (level),
        .i_rising (rising),
        .o_single (o_single),
        .o_double (o_double),
        .o_long   (o_long),
        .o_busy   (o_busy)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input int obs, input int exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s step=%0d obs=%0d exp=%0d", tag, n, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_mode = M_IDLE; m_ent = 0; m_rq = 0; m_armed = 0;
        m_single = 0; m_double = 0; m_long = 0;
    endtask

    task automatic clear_stats();
        sgl_cnt = 0; dbl_cnt = 0; lng_cnt = 0;
        sgl_step = -1; dbl_step = -1; lng_step = -1; sgl_busy = 1'b1;
    endtask

    task automatic step();
        logic lv, rs;
        bit press, rel;
        lv = level;
        rs = rising;
        @(posedge clk);
        m_single = 0; m_double = 0; m_long = 0;
        if (!rst_n) begin
            model_reset();
        end else begin
            press = rs && !m_rq && m_armed;
            rel   = !lv;
            case (m_mode)
                M_IDLE: if (press) begin m_mode = M_P1; m_ent = n; end
                M_P1: begin
                    if (rel) begin m_mode = M_GAP; m_ent = n; end
                    else if (n - m_ent >= L) begin m_mode = M_LONG; m_long = 1; end
                end
                M_LONG: if (rel) m_mode = M_IDLE;
                M_GAP: begin
                    if (press) m_mode = M_P2;
                    else if (n - m_ent >= D) begin m_mode = M_IDLE; m_single = 1; end
                end
                M_P2: if (rel) begin m_mode = M_IDLE; m_double = 1; end
                default: m_mode = M_IDLE;
            endcase
            m_armed = m_armed || !rs;
            m_rq    = rs;
        end
        #1;
        check_eq("single", int'(o_single), int'(m_single));
        check_eq("double", int'(o_double), int'(m_double));
        check_eq("long",   int'(o_long),   int'(m_long));
        check_eq("busy",   int'(o_busy),   int'(m_mode != M_IDLE));
        if (o_single === 1'b1) begin sgl_cnt++; sgl_step = n; sgl_busy = o_busy; end
        if (o_double === 1'b1) begin dbl_cnt++; dbl_step = n; end
        if (o_long === 1'b1)   begin lng_cnt++; lng_step = n; end
        n++;
    endtask

    task automatic drive(input logic lv, input logic rs, input int cycles);
        for (int k = 0; k < cycles; k++) begin
            level  = lv;
            rising = rs;
            step();
        end
    endtask

    int p, r, r2;

    initial begin
        rst_n = 1'b0; level = 1'b0; rising = 1'b0;
        model_reset();
        clear_stats();
        step();
        check_eq("rst_busy", int'(o_busy), 0);
        check_eq("rst_pulses", int'({o_single, o_double, o_long}), 0);
        rst_n = 1'b1;

        // 1: single press
        clear_stats();
        drive(0, 0, 5);
        p = n;
        drive(1, 1, 3);
        drive(1, 0, 5);
        r = n;
        drive(0, 0, D + 6);
        check_eq("s1_single_cnt", sgl_cnt, 1);
        check_eq("s1_single_lat", sgl_step - r, D);
        check_eq("s1_busy_with_pulse", int'(sgl_busy), 0);
        check_eq("s1_other", dbl_cnt + lng_cnt, 0);

        // 2: long press
        clear_stats();
        p = n;
        drive(1, 1, 3);
        drive(1, 0, 27);
        drive(0, 0, 15);
        check_eq("s2_long_cnt", lng_cnt, 1);
        check_eq("s2_long_lat", lng_step - p, L);
        check_eq("s2_other", sgl_cnt + dbl_cnt, 0);
        check_eq("s2_busy_end", int'(o_busy), 0);

        // 3: double press
        clear_stats();
        drive(1, 1, 2); drive(1, 0, 3);
        drive(0, 0, 4);
        drive(1, 1, 2); drive(1, 0, 3);
        r = n;
        drive(0, 0, D + 6);
        check_eq("s3_double_cnt", dbl_cnt, 1);
        check_eq("s3_double_lat", dbl_step - r, 0);
        check_eq("s3_single_cnt", sgl_cnt, 0);

        // 4: second press exactly when the gap expires
        clear_stats();
        drive(1, 1, 2); drive(1, 0, 3);
        r = n;
        drive(0, 0, D);
        drive(1, 1, 2); drive(1, 0, 2);
        r2 = n;
        drive(0, 0, D + 6);
        check_eq("s4_double_cnt", dbl_cnt, 1);
        check_eq("s4_double_lat", dbl_step - r2, 0);
        check_eq("s4_single_cnt", sgl_cnt, 0);

        // 5: release exactly when the long timer expires
        clear_stats();
        p = n;
        drive(1, 1, 2);
        drive(1, 0, L - 2);
        r = n;
        drive(0, 0, D + 6);
        check_eq("s5_release_step", r - p, L);
        check_eq("s5_long_cnt", lng_cnt, 0);
        check_eq("s5_single_cnt", sgl_cnt, 1);
        check_eq("s5_single_lat", sgl_step - r, D);

        // 6: reset mid-gap, rising held high across reset release
        clear_stats();
        drive(1, 1, 2); drive(1, 0, 3);
        drive(0, 0, 4);
        check_eq("s6_busy_gap", int'(o_busy), 1);
        rising = 1'b1; level = 1'b1;
        rst_n = 1'b0;
        #1;
        check_eq("s6_rst_busy", int'(o_busy), 0);
        check_eq("s6_rst_pulses", int'({o_single, o_double, o_long}), 0);
        model_reset();
        drive(1, 1, 2);
        rst_n = 1'b1;
        drive(1, 1, 5);
        drive(0, 0, D + 6);
        check_eq("s6_no_pulse", sgl_cnt + dbl_cnt + lng_cnt, 0);
        check_eq("s6_idle", int'(o_busy), 0);
        drive(1, 0, 1);
        drive(1, 1, 1);
        check_eq("s6_press_after_toggle", int'(o_busy), 1);
        drive(1, 0, 2);
        drive(0, 0, D + 4);

        // randomized gestures, including boundary hold and gap lengths
        for (int g = 0; g < 40; g++) begin
            int hold, gap, rl;
            drive(0, 0, $urandom_range(0, 3));
            hold = $urandom_range(1, L + 4);
            rl   = $urandom_range(1, hold);
            for (int k = 0; k < hold; k++)
                drive(1, (k < rl) ? 1'b1 : 1'($urandom_range(0, 7) == 0), 1);
            gap = $urandom_range(1, D + 2);
            drive(0, 0, gap);
            if ($urandom_range(0, 1) == 1) begin
                hold = $urandom_range(1, L + 4);
                drive(1, 1, 1);
                drive(1, 0, hold);
                drive(0, 0, $urandom_range(1, D + 2));
            end
        end
        drive(0, 0, L + D + 4);
        check_eq("final_idle", int'(o_busy), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
